// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM state encoding and op-decode helpers shared by the
// multiply/divide unit and its shift core.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } mdu_state_e;

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// mdu_shift_core: one radix-2 step per cycle on unsigned magnitudes; shift-add
// multiply into {acc,quo} or restoring divide leaving remainder in acc, quotient in quo.
module mdu_shift_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div_op,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, b_q, b_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_addend, rem_sub;
  logic [WIDTH:0]   add_sum, shifted;
  logic             ge;

  always_comb begin
    acc_d      = acc_q;
    quo_d      = quo_q;
    b_d        = b_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    mul_addend = quo_q[0] ? b_q : {WIDTH{1'b0}};
    add_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
    shifted    = {acc_q, quo_q[WIDTH-1]};
    ge         = shifted >= {1'b0, b_q};
    // remainder is always below the divisor, so the W-bit wrap is exact
    rem_sub    = shifted[WIDTH-1:0] - b_q;
    if (load) begin
      acc_d = '0;
      quo_d = a_mag;
      b_d   = b_mag;
      div_d = is_div_op;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        acc_d = ge ? rem_sub : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
      end else begin
        acc_d = add_sum[WIDTH:1];
        quo_d = {add_sum[0], quo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      quo_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      quo_q <= quo_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign quo  = quo_q;
  assign last = step && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide with architectural HI/LO and hazard stall/done.
// Define MUL_DIV_UNIT_MADD_EN to make MADD/MADDU/MSUB/MSUBU accumulate into {HI,LO}.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             stall,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic               issue, core_last;
  logic [WIDTH-1:0]   a_mag, b_mag, core_acc, core_quo;
  logic               sgn_a, sgn_b;
  logic [2*WIDTH-1:0] prod, prod_s, mul_res;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

  assign issue = (state_q == ST_IDLE) && start && !cancel;
  assign a_mag = (is_signed(op) && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag = (is_signed(op) && src_b[WIDTH-1]) ? -src_b : src_b;

  mdu_shift_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (issue),
    .step     (state_q == ST_CALC),
    .is_div_op(is_div(op)),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc      (core_acc),
    .quo      (core_quo),
    .last     (core_last)
  );

  // Sign fixup and optional accumulate on the magnitude result; the outcome is
  // committed to HI/LO on the edge leaving FIXUP.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    sgn_a  = is_signed(op_q) && a_q[WIDTH-1];
    sgn_b  = is_signed(op_q) && b_q[WIDTH-1];
    prod   = {core_acc, core_quo};
    prod_s = (sgn_a ^ sgn_b) ? -prod : prod;
`ifdef MUL_DIV_UNIT_MADD_EN
    if (is_acc(op_q)) begin
      mul_res = is_sub(op_q) ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
    end else begin
      mul_res = prod_s;
    end
`else
    mul_res = prod_s;
`endif
    quot = (sgn_a ^ sgn_b) ? -core_quo : core_quo;
    rem  = sgn_a ? -core_acc : core_acc;
    if (is_div(op_q)) begin
      if (b_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end else begin
      res_hi = mul_res[2*WIDTH-1:WIDTH];
      res_lo = mul_res[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        // mt writes land before an op issued in the same cycle reads HI/LO
        if (mthi) hi_d = src_a;
        if (mtlo) lo_d = src_a;
        if (start && !cancel) begin
          state_d = ST_CALC;
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
        end
      end
      ST_CALC: begin
        if (cancel)         state_d = ST_IDLE;
        else if (core_last) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign stall = issue || busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit, checked every cycle against an
// arithmetic model (countdown + longint math) and against hand-computed literals.
module tb_mul_div_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;
  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MADD = 3'd4, MADDU = 3'd5, MSUB = 3'd6, MSUBU = 3'd7;
`ifdef MUL_DIV_UNIT_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, cancel = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] src_a = '0, src_b = '0;
  logic             stall, done, busy;
  logic [WIDTH-1:0] hi, lo;

  int   checks = 0;
  int   passes = 0;
  logic cmp_en = 1'b0;

  int                 m_left = 0;
  logic [WIDTH-1:0]   m_hi = '0, m_lo = '0, nh, nl;
  logic [2*WIDTH-1:0] m_pend = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .cancel(cancel),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .stall (stall),
    .done  (done),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Architectural result {hi,lo} of one op from plain arithmetic.
  function automatic logic [63:0] expected_result(input logic [2:0] o, input logic [31:0] a,
                                                  input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == DIV || o == DIVU) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (o == DIVU) begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    if (o == MULT || o == MADD || o == MSUB) p = sa * sb;
    else                                     p = {32'd0, a} * {32'd0, b};
    if (MADD_EN && (o == MADD || o == MADDU)) return acc + p;
    if (MADD_EN && (o == MSUB || o == MSUBU)) return acc - p;
    return p;
  endfunction

  // Model: m_left counts cycles until idle; the result lands when entering the last one.
  always @(posedge clk) begin
    nh = m_hi;
    nl = m_lo;
    if (rst) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left == 0) begin
      if (mthi) nh = src_a;
      if (mtlo) nl = src_a;
      m_hi <= nh;
      m_lo <= nl;
      if (start && !cancel) begin
        m_pend <= expected_result(op, src_a, src_b, {nh, nl});
        m_left <= LAT;
      end
    end else if (cancel) begin
      m_left <= 0;
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) {m_hi, m_lo} <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("busy",  busy,  m_left != 0);
      checkOutput("done",  done,  m_left == 1);
      checkOutput("stall", stall, (m_left != 0) || (start && !cancel));
      checkOutput("hi",    hi,    m_hi);
      checkOutput("lo",    lo,    m_lo);
    end
  end

  task automatic writeHiLo(input logic [31:0] h, input logic [31:0] l);
    @(posedge clk); #1;
    mthi = 1'b1; src_a = h;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b1; src_a = l;
    @(posedge clk); #1;
    mtlo = 1'b0;
  endtask

  // Issue one op, scramble operands and poke ignored start/mt while busy, wait for done.
  task automatic applyStimulus(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic ml,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   lat;
    logic seen;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b; mtlo = ml;
    @(negedge clk);
    checkOutput({name, " stall on issue"}, stall, 1'b1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 3 * LAT) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == 5);
      mthi  = (lat == 5);
      mtlo  = (lat == 5);
      op    = (lat == 5) ? DIVU : o;
      src_a = $urandom;
      src_b = $urandom;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput({name, " latency"}, lat, LAT);
    checkOutput({name, " hi"}, hi, exp_hi);
    checkOutput({name, " lo"}, lo, exp_lo);
    checkOutput({name, " stall at done"}, stall, 1'b1);
  endtask

  initial begin
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(negedge clk);
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset stall", stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus("MULT -1*2",   MULT,  32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    applyStimulus("MULTU b2b",   MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    applyStimulus("DIV -7/2",    DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus("DIVU 100/7",  DIVU,  32'd100,       32'd7, 1'b0, 32'd2,         32'd14);
    applyStimulus("DIVU 5/0",    DIVU,  32'd5,         32'd0, 1'b0, 32'd5,         32'hFFFF_FFFF);
    applyStimulus("DIV ovf",     DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);

    @(posedge clk); #1;
    mthi = 1'b1; src_a = 32'h1234;
    @(posedge clk); #1;
    mthi = 1'b0; start = 1'b1; op = DIV; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    checkOutput("cancel busy", busy, 1'b0);
    checkOutput("cancel done", done, 1'b0);
    checkOutput("cancel hi", hi, 32'h1234);
    repeat (LAT) @(negedge clk);

    writeHiLo(32'h0, 32'hFFFF_FFFF);
    applyStimulus("MADDU 1*1", MADDU, 32'd1, 32'd1, 1'b0,
                  MADD_EN ? 32'h1 : 32'h0, MADD_EN ? 32'h0 : 32'h1);
    writeHiLo(32'h0, 32'd5);
    applyStimulus("MSUB 2*3", MSUB, 32'd2, 32'd3, 1'b0,
                  MADD_EN ? 32'hFFFF_FFFF : 32'h0, MADD_EN ? 32'hFFFF_FFFF : 32'd6);
    writeHiLo(32'h0, 32'h0);
    applyStimulus("MTLO+MADDU 3*4", MADDU, 32'd3, 32'd4, 1'b1,
                  32'h0, MADD_EN ? 32'd15 : 32'd12);

    @(posedge clk); #1;
    start = 1'b1; op = MULTU; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst mid-op busy", busy, 1'b0);
    checkOutput("rst mid-op hi", hi, 32'h0);
    checkOutput("rst mid-op lo", lo, 32'h0);
    repeat (LAT) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
